cdm_msgld_traffic_gen: RTL

CDM_MSGLD_TRAFFIC_GEN -- requirements
Module: cdm_msgld_traffic_gen

---
 rtl/cdm_msgld_traffic_gen_if.sv | 28 ++
 rtl/cdm_msgld_traffic_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cdm_msgld_traffic_gen_if.sv
// Message-load request and response-data channels between the traffic generator and its buffers.
interface cdm_msgld_traffic_gen_if #(
  parameter int unsigned NUM_TAGS = 8,
  parameter int unsigned DATA_W   = 256
);
  localparam int unsigned TAG_W = $clog2(NUM_TAGS);

  logic              req_vld;
  logic              req_rdy;
  logic [63:0]       req_addr;
  logic [7:0]        req_len;
  logic [TAG_W-1:0]  req_tag;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_last;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_vld, req_addr, req_len, req_tag, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_tag, rsp_last, rsp_err, rsp_data
  );
  modport slave (
    input  req_vld, req_addr, req_len, req_tag, rsp_rdy,
    output req_rdy, rsp_vld, rsp_tag, rsp_last, rsp_err, rsp_data
  );
endinterface

// File: rtl/cdm_msgld_traffic_gen.sv
// Message-load traffic generator: issues strided tagged requests, tracks response beats per tag,
// counts completions and protocol errors.
module cdm_msgld_traffic_gen #(
  parameter int unsigned NUM_TAGS = 8,
  parameter int unsigned DATA_W   = 256,
  parameter int unsigned TCQ      = 1
) (
  input  logic        user_clk,
  input  logic        user_reset,
  input  logic        start,
  input  logic [15:0] num_req,
  input  logic [63:0] base_addr,
  input  logic [31:0] stride,
  input  logic [7:0]  len_beats,
  cdm_msgld_traffic_gen_if.master bus,
  output logic        busy,
  output logic        done,
  output logic [15:0] cmpl_cnt,
  output logic [15:0] err_cnt
);
  localparam int unsigned TAG_W = $clog2(NUM_TAGS);
  localparam int unsigned CNT_W = 9;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        num_req_q, num_req_d;
  logic [15:0]        issued_q, issued_d;
  logic [7:0]         len_q, len_d;
  logic [31:0]        stride_q, stride_d;
  logic [63:0]        next_addr_q, next_addr_d;
  logic [NUM_TAGS-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   beat_cnt_q [NUM_TAGS];
  logic [CNT_W-1:0]   beat_cnt_d [NUM_TAGS];
  logic               req_vld_q, req_vld_d;
  logic [63:0]        req_addr_q, req_addr_d;
  logic [7:0]         req_len_q, req_len_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic               rsp_rdy_q, rsp_rdy_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        cmpl_q, cmpl_d;
  logic [15:0]        err_q, err_d;

  logic               req_acc, rsp_acc, err_inc, cmpl_inc, free_tag_ok;
  logic [NUM_TAGS-1:0] free_mask, alloc_mask;
  logic [CNT_W-1:0]   beat_nxt;
  logic [TAG_W-1:0]   free_tag;

  // Response data and the clock-to-q parameter carry no information for this logic.
  logic unused_sink;
  assign unused_sink = ^{bus.rsp_data, 32'(TCQ)};

  // Next-state, tag bookkeeping, counters and registered-output values.
  always_comb begin
    state_d       = state_q;
    num_req_d     = num_req_q;
    issued_d      = issued_q;
    len_d         = len_q;
    stride_d      = stride_q;
    next_addr_d   = next_addr_q;
    beat_cnt_d    = beat_cnt_q;
    req_vld_d     = req_vld_q;
    req_addr_d    = req_addr_q;
    req_len_d     = req_len_q;
    req_tag_d     = req_tag_q;
    cmpl_d        = cmpl_q;
    err_d         = err_q;
    err_inc       = 1'b0;
    cmpl_inc      = 1'b0;
    free_mask     = '0;
    alloc_mask    = '0;
    beat_nxt      = '0;
    free_tag      = '0;
    free_tag_ok   = 1'b0;
    req_acc       = req_vld_q & bus.req_rdy;
    rsp_acc       = bus.rsp_vld & rsp_rdy_q;

    // Beat accounting; at most one error per beat.
    if (rsp_acc) begin
      if (!outstanding_q[bus.rsp_tag]) begin
        err_inc = 1'b1;
      end else begin
        beat_nxt = (beat_cnt_q[bus.rsp_tag] == '1) ? '1 : beat_cnt_q[bus.rsp_tag] + CNT_W'(1);
        if (bus.rsp_last) begin
          free_mask[bus.rsp_tag] = 1'b1;
          cmpl_inc = 1'b1;
          err_inc  = bus.rsp_err | (beat_nxt != CNT_W'(len_q));
        end else begin
          beat_cnt_d[bus.rsp_tag] = beat_nxt;
          err_inc = bus.rsp_err | (beat_nxt > CNT_W'(len_q));
        end
      end
    end

    // Request acceptance allocates the presented tag and advances the address.
    if (req_acc) begin
      alloc_mask[req_tag_q]  = 1'b1;
      beat_cnt_d[req_tag_q]  = '0;
      issued_d               = issued_q + 16'd1;
      next_addr_d            = next_addr_q + 64'(stride_q);
    end
    outstanding_d = (outstanding_q & ~free_mask) | alloc_mask;

    if (cmpl_inc && (cmpl_q != 16'hFFFF)) cmpl_d = cmpl_q + 16'd1;
    if (err_inc && (err_q != 16'hFFFF))   err_d  = err_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          num_req_d     = num_req;
          len_d         = (len_beats == 8'd0) ? 8'd1 : len_beats;
          stride_d      = stride;
          next_addr_d   = base_addr;
          issued_d      = '0;
          cmpl_d        = '0;
          err_d         = '0;
          outstanding_d = '0;
          state_d       = (num_req == 16'd0) ? DONE : ISSUE;
        end
      end
      ISSUE:   if (req_acc && (issued_d == num_req_q)) state_d = DRAIN;
      DRAIN:   if (outstanding_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Lowest-numbered tag free after this edge.
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!outstanding_d[i]) begin
        free_tag_ok = 1'b1;
        free_tag    = TAG_W'(i);
      end
    end

    // A stalled request keeps its payload; otherwise present the next one.
    if (req_vld_q && !bus.req_rdy) begin
      req_vld_d = 1'b1;
    end else begin
      req_vld_d  = (state_d == ISSUE) && (issued_d < num_req_d) && free_tag_ok;
      req_addr_d = next_addr_d;
      req_len_d  = len_d;
      req_tag_d  = free_tag;
    end

    busy_d    = (state_d == ISSUE) || (state_d == DRAIN);
    rsp_rdy_d = busy_d;
    done_d    = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q       <= IDLE;
      num_req_q     <= '0;
      issued_q      <= '0;
      len_q         <= 8'd1;
      stride_q      <= '0;
      next_addr_q   <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < int'(NUM_TAGS); i++) beat_cnt_q[i] <= '0;
      req_vld_q     <= 1'b0;
      req_addr_q    <= '0;
      req_len_q     <= '0;
      req_tag_q     <= '0;
      rsp_rdy_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cmpl_q        <= '0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      num_req_q     <= num_req_d;
      issued_q      <= issued_d;
      len_q         <= len_d;
      stride_q      <= stride_d;
      next_addr_q   <= next_addr_d;
      outstanding_q <= outstanding_d;
      beat_cnt_q    <= beat_cnt_d;
      req_vld_q     <= req_vld_d;
      req_addr_q    <= req_addr_d;
      req_len_q     <= req_len_d;
      req_tag_q     <= req_tag_d;
      rsp_rdy_q     <= rsp_rdy_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cmpl_q        <= cmpl_d;
      err_q         <= err_d;
    end
  end

  assign bus.req_vld  = req_vld_q;
  assign bus.req_addr = req_addr_q;
  assign bus.req_len  = req_len_q;
  assign bus.req_tag  = req_tag_q;
  assign bus.rsp_rdy  = rsp_rdy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cmpl_cnt     = cmpl_q;
  assign err_cnt      = err_q;
endmodule
